lut_fir_mac: RTL and testbench

LUT_FIR_MAC -- requirements
Module: lut_fir_mac

---
 rtl/lut_fir_mac.sv | 147 ++++++++++++++
 tb/tb_lut_fir_mac.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lut_fir_mac.sv
// lut_fir_mac: pipelined direct-form FIR filter with a writable coefficient
// register file and a width-converting output stage (clamp or truncate).
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset (clears all state, coefs included)
//   in_valid   x_in carries a new sample this cycle
//   x_in       unsigned input sample, XW bits
//   flush      synchronous clear of delay line, products and valid pipeline
//   coef_we    coefficient write strobe
//   coef_addr  tap index to write (indices >= TAPS are ignored)
//   coef_data  unsigned coefficient value, CW bits
//   out_valid  out carries a new result this cycle (one pulse per sample)
//   out        filter output, OW bits, holds between results
//   sat_flag   the result in out was clamped or truncated (only with out_valid)
//
// Handshake: in_valid has no back-pressure; every cycle with in_valid=1 and
// flush=0 accepts x_in, and exactly one out_valid pulse follows two edges
// after the accepting edge. Gaps on the input reproduce as gaps on the output.
module lut_fir_mac #(
  parameter int TAPS = 10,
  parameter int XW   = 4,
  parameter int CW   = 8,
  parameter int OW   = 16,
  parameter int SAT  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [XW-1:0] x_in,
  input  logic          flush,
  input  logic          coef_we,
  input  logic [4:0]    coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic          out_valid,
  output logic [OW-1:0] out,
  output logic          sat_flag
);

  localparam int PW = XW + CW;                 // one product
  localparam int FW = XW + CW + $clog2(TAPS);  // full-precision sum

  logic [XW-1:0] tap  [TAPS];
  logic [CW-1:0] coef [TAPS];
  logic [PW-1:0] p    [TAPS];

  // v_tap: the delay line took a sample at the last edge.
  // v_prod: the product registers hold that sample's products.
  logic v_tap;
  logic v_prod;

  logic [FW-1:0] sum;
  logic [OW-1:0] out_next;
  logic          sat_next;

  // Adder tree over the registered products; FW bits cannot overflow.
  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum = sum + FW'(p[k]);
    end
  end

  // Width conversion from FW to OW.
  generate
    if (OW >= FW) begin : g_wide
      always_comb begin
        out_next = OW'(sum);
        sat_next = 1'b0;
      end
    end else if (SAT != 0) begin : g_clamp
      // Any set bit above OW-1 means sum > 2^OW-1.
      always_comb begin
        sat_next = |sum[FW-1:OW];
        out_next = sat_next ? {OW{1'b1}} : sum[OW-1:0];
      end
    end else begin : g_trunc
      always_comb begin
        sat_next = |sum[FW-1:OW];
        out_next = sum[OW-1:0];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        tap[k]  <= '0;
        coef[k] <= '0;
        p[k]    <= '0;
      end
      v_tap     <= 1'b0;
      v_prod    <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      // Coefficient writes are independent of flush; out-of-range
      // addresses simply match no tap.
      for (int k = 0; k < TAPS; k++) begin
        if (coef_we && coef_addr == 5'(k)) begin
          coef[k] <= coef_data;
        end
      end

      if (flush) begin
        // Drops everything in flight, including a sample offered this
        // cycle; out keeps its last value.
        for (int k = 0; k < TAPS; k++) begin
          tap[k] <= '0;
          p[k]   <= '0;
        end
        v_tap     <= 1'b0;
        v_prod    <= 1'b0;
        out_valid <= 1'b0;
        sat_flag  <= 1'b0;
      end else begin
        // Stage 0: delay line.
        v_tap <= in_valid;
        if (in_valid) begin
          tap[0] <= x_in;
          for (int k = 1; k < TAPS; k++) begin
            tap[k] <= tap[k-1];
          end
        end

        // Stage 1: products, using coefficients as of the previous edge.
        v_prod <= v_tap;
        if (v_tap) begin
          for (int k = 0; k < TAPS; k++) begin
            p[k] <= PW'(tap[k]) * PW'(coef[k]);
          end
        end

        // Stage 2: sum and width conversion.
        out_valid <= v_prod;
        if (v_prod) begin
          out      <= out_next;
          sat_flag <= sat_next;
        end else begin
          sat_flag <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lut_fir_mac.sv
// tb_lut_fir_mac: directed and randomized checks of lut_fir_mac at default
// width (OW=16) plus two narrow-output variants (OW=11 clamp, OW=11 wrap)
// sharing the same stimulus. Expected results come from a sample-history
// model: each accepted sample yields sum(hist[k]*coef[k]) due two edges later.
module tb_lut_fir_mac;

  localparam int TAPS = 10;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] x_in;
  logic       flush;
  logic       coef_we;
  logic [4:0] coef_addr;
  logic [7:0] coef_data;

  logic        ov_w, ov_s, ov_t;
  logic [15:0] out_w;
  logic [10:0] out_s, out_t;
  logic        sf_w, sf_s, sf_t;

  lut_fir_mac dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x_in(x_in), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(ov_w), .out(out_w), .sat_flag(sf_w)
  );

  lut_fir_mac #(.OW(11), .SAT(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x_in(x_in), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(ov_s), .out(out_s), .sat_flag(sf_s)
  );

  lut_fir_mac #(.OW(11), .SAT(0)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x_in(x_in), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(ov_t), .out(out_t), .sat_flag(sf_t)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  typedef struct { int due; int sum; } pend_t;
  pend_t pq[$];
  int hist [TAPS];
  int mcoef[TAPS];
  int cyc;
  int last_sum;
  int pulses;

  int checks;
  int failures;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input bit ev);
    int s;
    s = last_sum;
    chk("w_valid", 32'(ov_w), 32'(ev));
    chk("w_out",   32'(out_w), 32'(s));
    chk("w_sat",   32'(sf_w), 32'b0);
    chk("s_valid", 32'(ov_s), 32'(ev));
    chk("s_out",   32'(out_s), 32'((s > 2047) ? 2047 : s));
    chk("s_sat",   32'(sf_s), 32'(ev && s > 2047));
    chk("t_valid", 32'(ov_t), 32'(ev));
    chk("t_out",   32'(out_t), 32'(s % 2048));
    chk("t_sat",   32'(sf_t), 32'(ev && s >= 2048));
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      hist[k]  = 0;
      mcoef[k] = 0;
    end
    pq.delete();
    last_sum = 0;
  endtask

  // Driver: one clock cycle with the given inputs, model update, output check.
  task automatic step(input bit iv, input int x, input bit fl,
                      input bit we, input int addr, input int data);
    bit ev;
    pend_t e;
    int s;
    @(negedge clk);
    in_valid  = iv;
    x_in      = 4'(x);
    flush     = fl;
    coef_we   = we;
    coef_addr = 5'(addr);
    coef_data = 8'(data);
    @(posedge clk);
    cyc++;
    if (fl) begin
      for (int k = 0; k < TAPS; k++) hist[k] = 0;
      pq.delete();
    end else if (iv) begin
      for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = x;
    end
    if (we && addr < TAPS) mcoef[addr] = data;
    if (iv && !fl) begin
      s = 0;
      for (int k = 0; k < TAPS; k++) s += hist[k] * mcoef[k];
      e.due = cyc + 2;
      e.sum = s;
      pq.push_back(e);
    end
    ev = 1'b0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      e = pq.pop_front();
      last_sum = e.sum;
      ev = 1'b1;
      pulses++;
    end
    #1;
    check_outputs(ev);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Asserts reset between edges and checks outputs clear without a clock.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    x_in      = '0;
    flush     = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    #1;
    model_reset();
    check_outputs(1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_coefs_ramp();
    for (int k = 0; k < TAPS; k++) step(0, 0, 0, 1, k, k + 1);
  endtask

  task automatic impulse();
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < TAPS - 1; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int p0;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    pulses   = 0;
    model_reset();
    rst_n = 1'b1;
    in_valid = 1'b0; x_in = '0; flush = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    #1;
    async_reset();

    // Impulse response with coef[k]=k+1 -> 1..10 then zeros.
    load_coefs_ramp();
    p0 = pulses;
    impulse();
    idle(4);
    chk("impulse_pulses", 32'(pulses - p0), 32'd10);

    // Gapped impulse: same response, valid only for accepted samples.
    p0 = pulses;
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TAPS - 1; i++) begin
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
    end
    idle(3);
    chk("gapped_pulses", 32'(pulses - p0), 32'd10);

    // Flush after the 4th response sample, then a clean impulse.
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 7, 1, 0, 0, 0);
    idle(4);
    impulse();
    idle(4);

    // Coefficient writes during streaming, including an out-of-range index.
    for (int i = 0; i < 6; i++) step(1, $urandom_range(0, 15), 0, 0, 0, 0);
    step(1, $urandom_range(0, 15), 0, 1, 3, 9);
    for (int i = 0; i < 4; i++) step(1, $urandom_range(0, 15), 0, 0, 0, 0);
    step(1, $urandom_range(0, 15), 0, 1, 20, 200);
    for (int i = 0; i < 12; i++) step(1, $urandom_range(0, 15), 0, 0, 0, 0);
    idle(3);

    // Full scale: ramp to 38250, clamp / wrap on the narrow variants.
    for (int k = 0; k < TAPS; k++) step(0, 0, 0, 1, k, 255);
    for (int i = 0; i < 12; i++) step(1, 15, 0, 0, 0, 0);
    idle(3);
    chk("fullscale_sum", 32'(last_sum), 32'd38250);

    // Async reset mid-stream: coefs cleared, impulse gives zeros on time.
    for (int i = 0; i < 3; i++) step(1, 15, 0, 0, 0, 0);
    async_reset();
    p0 = pulses;
    impulse();
    idle(4);
    chk("post_reset_pulses", 32'(pulses - p0), 32'd10);

    // Randomized traffic.
    load_coefs_ramp();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15),
           $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 31), $urandom_range(0, 255));
    end
    idle(4);
    chk("queue_drained", 32'(pq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
